// File: rtl/tcp_tx_rr_arbiter.sv
// Purpose: round-robin TX arbiter; N_CH user channels share one meta+payload path into the TCP stack, status words routed back by grant order.
// Latency: meta 1 cycle after request (IDLE -> META); payload and status are 0-cycle combinational pass-through.
// Backpressure: meta held until m_meta_ready; payload tready mirrors m_axis_tready for the granted channel only; status stalls on the owning channel's ready.
// Ports: aclk/aresetn; s_meta_* (per-channel {len,sid}) -> m_meta_*; s_axis_* (per-channel payload) -> m_axis_*;
//        s_stat_* (stack status) -> m_stat_* (valid steered to originating channel, data broadcast); err_orphan (sticky).
module tcp_tx_rr_arbiter #(
    parameter int N_CH      = 4,
    parameter int DATA_BITS = 512,
    parameter int SID_BITS  = 16,
    parameter int LEN_BITS  = 16,
    parameter int STAT_BITS = 64,
    parameter int ORD_DEPTH = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [N_CH-1:0]                       s_meta_valid,
    output logic [N_CH-1:0]                       s_meta_ready,
    input  logic [N_CH*(SID_BITS+LEN_BITS)-1:0]   s_meta_data,
    output logic                                  m_meta_valid,
    input  logic                                  m_meta_ready,
    output logic [SID_BITS+LEN_BITS-1:0]          m_meta_data,
    input  logic                                  s_stat_valid,
    output logic                                  s_stat_ready,
    input  logic [STAT_BITS-1:0]                  s_stat_data,
    output logic [N_CH-1:0]                       m_stat_valid,
    input  logic [N_CH-1:0]                       m_stat_ready,
    output logic [STAT_BITS-1:0]                  m_stat_data,
    input  logic [N_CH-1:0]                       s_axis_tvalid,
    output logic [N_CH-1:0]                       s_axis_tready,
    input  logic [N_CH-1:0]                       s_axis_tlast,
    input  logic [N_CH*DATA_BITS-1:0]             s_axis_tdata,
    input  logic [N_CH*DATA_BITS/8-1:0]           s_axis_tkeep,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic [DATA_BITS-1:0]                  m_axis_tdata,
    output logic [DATA_BITS/8-1:0]                m_axis_tkeep,
    output logic                                  err_orphan
);
    localparam int MW    = SID_BITS + LEN_BITS;
    localparam int KW    = DATA_BITS / 8;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W = $clog2(ORD_DEPTH);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, META, DATA} state_t;

    state_t               state_q, state_d;
    logic [CH_W-1:0]      gnt_q, gnt_d;
    logic [CH_W-1:0]      last_q, last_d;
    logic [CNT_W-1:0]     outst_q [N_CH];
    logic [CNT_W-1:0]     outst_d [N_CH];
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
    logic                 err_orphan_q, err_orphan_d;
    logic [CH_W-1:0]      ord_mem_q [ORD_DEPTH];

    logic                 fifo_empty, fifo_full;
    logic [CH_W-1:0]      head;
    logic                 push, pop, orphan_set;
    logic                 pick_vld;
    logic [CH_W-1:0]      pick_ch, cand;
    logic [N_CH-1:0]      elig;
    logic [MW-1:0]        gnt_meta;
    logic [LEN_BITS-1:0]  gnt_len;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = ord_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign gnt_meta   = s_meta_data[int'(gnt_q)*MW +: MW];
    assign gnt_len    = gnt_meta[MW-1:SID_BITS];
    assign err_orphan = err_orphan_q;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        pick_vld = 1'b0;
        pick_ch  = last_q;
        cand     = '0;
        for (int c = 0; c < N_CH; c++) begin
            elig[c] = s_meta_valid[c] && (outst_q[c] < CNT_W'(MAX_OUTST)) && !fifo_full;
        end
        for (int i = 1; i <= N_CH; i++) begin
            cand = CH_W'((int'(last_q) + i) % N_CH);
            if (!pick_vld && elig[cand]) begin
                pick_vld = 1'b1;
                pick_ch  = cand;
            end
        end
    end

    // Grant FSM and meta/payload muxing; outputs are zero outside their state.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_d        = last_q;
        push          = 1'b0;
        m_meta_valid  = 1'b0;
        m_meta_data   = '0;
        s_meta_ready  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        s_axis_tready = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick_ch;
                    state_d = META;
                end
            end
            META: begin
                m_meta_valid        = 1'b1;
                m_meta_data         = gnt_meta;
                s_meta_ready[gnt_q] = m_meta_ready;
                if (m_meta_ready) begin
                    push    = 1'b1;
                    last_d  = gnt_q;
                    state_d = (gnt_len == '0) ? IDLE : DATA;
                end
            end
            DATA: begin
                m_axis_tvalid        = s_axis_tvalid[gnt_q];
                m_axis_tlast         = s_axis_tlast[gnt_q];
                m_axis_tdata         = s_axis_tdata[int'(gnt_q)*DATA_BITS +: DATA_BITS];
                m_axis_tkeep         = s_axis_tkeep[int'(gnt_q)*KW +: KW];
                s_axis_tready[gnt_q] = m_axis_tready;
                if (s_axis_tvalid[gnt_q] && m_axis_tready && s_axis_tlast[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status return: steered by the order FIFO head, independent of the FSM.
    // Gated by aresetn so the always-ready orphan sink stays quiet in reset.
    always_comb begin
        m_stat_valid = '0;
        m_stat_data  = '0;
        s_stat_ready = 1'b0;
        pop          = 1'b0;
        orphan_set   = 1'b0;
        if (aresetn) begin
            m_stat_data = s_stat_data;
            if (fifo_empty) begin
                s_stat_ready = 1'b1;
                orphan_set   = s_stat_valid;
            end else begin
                m_stat_valid[head] = s_stat_valid;
                s_stat_ready       = m_stat_ready[head];
                pop                = s_stat_valid && m_stat_ready[head];
            end
        end
    end

    // Credit counters; a same-cycle grant and return on one channel cancel out.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + (PTR_W+1)'(push);
        rd_ptr_d     = rd_ptr_q + (PTR_W+1)'(pop);
        err_orphan_d = err_orphan_q | orphan_set;
        for (int c = 0; c < N_CH; c++) begin
            outst_d[c] = outst_q[c];
            if (push && (gnt_q == CH_W'(c)) && !(pop && (head == CH_W'(c)))) begin
                outst_d[c] = outst_q[c] + CNT_W'(1);
            end else if (pop && (head == CH_W'(c)) && !(push && (gnt_q == CH_W'(c)))) begin
                outst_d[c] = outst_q[c] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            last_q       <= CH_W'(N_CH - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            err_orphan_q <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                outst_q[c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_orphan_q <= err_orphan_d;
            for (int c = 0; c < N_CH; c++) begin
                outst_q[c] <= outst_d[c];
            end
        end
    end

    // Order storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge aclk) begin
        if (push) begin
            ord_mem_q[wr_ptr_q[PTR_W-1:0]] <= gnt_q;
        end
    end

endmodule

// File: doc/tcp_tx_rr_arbiter.md
# tcp_tx_rr_arbiter

- Parametrised N-channel TCP transmit arbiter between user regions and the network stack TX path.
- Grants TX metadata round-robin and forwards the winner's payload to the stack until `tlast`.
- Records the grant order so the stack's TX status responses return to the originating channel.
- Limits per-channel outstanding (unacknowledged) transfers with a credit counter.

## Interface
Parameters:
- `N_CH`, 4, number of user channels (2..16)
- `DATA_BITS`, 512, AXI4S data width; `tkeep` is DATA_BITS/8
- `SID_BITS`, 16, session id width
- `LEN_BITS`, 16, transfer length width (bytes)
- `STAT_BITS`, 64, TX status word width
- `ORD_DEPTH`, 16, order FIFO depth (power of 2)
- `MAX_OUTST`, 4, max outstanding transfers per channel (1..15)

Ports (clock and reset first):
- `aclk`  in  1  clock
- `aresetn`  in  1  asynchronous, active-low reset
- `s_meta_valid/ready`  in/out  N_CH  per-channel TX meta handshake
- `s_meta_data`  in  N_CH×(SID_BITS+LEN_BITS)  {len, sid} per channel
- `m_meta_valid/ready`  out/in  1  meta to stack
- `m_meta_data`  out  SID_BITS+LEN_BITS  granted meta
- `s_stat_valid/ready`  in/out  1  status from stack
- `s_stat_data`  in  STAT_BITS  status word
- `m_stat_valid/ready`  out/in  N_CH  per-channel status
- `m_stat_data`  out  STAT_BITS  status word, broadcast to all channels
- `s_axis_tvalid/tready/tlast`  in/out/in  N_CH  per-channel payload
- `s_axis_tdata`, `s_axis_tkeep`  in  N_CH×DATA_BITS, N_CH×DATA_BITS/8
- `m_axis_*`  out/in  single payload stream to stack
- `err_orphan`  out  1  sticky: status received with order FIFO empty

## Operation
- FSM states: IDLE, META, DATA.
- IDLE: eligible channel = `s_meta_valid` high, `outst[ch] < MAX_OUTST`, and order FIFO not full. Round-robin pick starts at `(last+1) mod N_CH`. Register `gnt` and go to META. Stay in IDLE if no channel is eligible.
- META: `m_meta_valid`=1 and `m_meta_data`=`s_meta_data[gnt]`; `s_meta_ready[gnt]` = `m_meta_ready`.
- On META handshake:
  - push `gnt` to order FIFO, increment `outst[gnt]`, `last<=gnt`;
  - len==0 → IDLE, otherwise → DATA.
- DATA: `m_axis_*` = `s_axis_*[gnt]` combinationally; `s_axis_tready[gnt]` = `m_axis_tready`; all other channels' tready=0. Handshake with `tlast` → IDLE. Beat count is not checked against len.
- Status return:
  - `m_stat_valid[h]` = `s_stat_valid` && FIFO non-empty, where h = FIFO head;
  - `s_stat_ready` = `m_stat_ready[h]`;
  - on handshake: pop FIFO, decrement `outst[h]`.
- Simultaneous increment and decrement of the same counter: counter unchanged.
- Status while FIFO empty: `s_stat_ready`=1, word dropped, `err_orphan`<=1. `err_orphan` is cleared only by reset.
- Status path is independent of the FSM; it may complete in any state.

## Timing
- Reset (async assert, sync release): state=IDLE, `last`=N_CH-1 (channel 0 first), `outst`=0, FIFO empty, `err_orphan`=0.
- All valid/ready outputs are 0 during reset; data outputs are 0.
- Meta latency: `s_meta_valid` high in IDLE → `m_meta_valid` high the next cycle.
- Payload and status paths: 0-cycle combinational pass-through.
- Per-packet overhead: 1 IDLE cycle + ≥1 META cycle. Back-to-back packets therefore show a 2-cycle bubble after `tlast`.
- `m_meta_valid` is held, with stable data, until the handshake completes. Grant never changes mid-packet.
- Deasserting `s_meta_valid[gnt]` in META is a protocol violation; behaviour is undefined.
- Order FIFO full: no new grants; an in-flight DATA packet completes.
- Credit at MAX_OUTST: the channel is skipped and the rest proceed. A status pop in cycle t makes the channel eligible at t+1.

## Test plan
- Reset, then ch0 and ch2 both request len=128 (2 beats): grant order ch0 then ch2. `m_meta` appears 1 cycle after request; 2 beats each forwarded.
- All 4 channels request continuously, 1-beat packets, MAX_OUTST=4, stat returned promptly: grant sequence is 0,1,2,3,0,…; status words route back in the same order.
- ch1 issues 4 packets with no status returned: 5th request blocked while ch3 is still granted. One status to ch1 → ch1 granted again.
- Meta with len=0 on ch2: meta forwarded, FSM returns to IDLE with no data beat, and a status still routes to ch2.
- Status with FIFO empty after reset: accepted, `err_orphan`=1 and stays 1. Reset clears it.
- `aresetn` pulled low mid-DATA: all outputs drop to 0 immediately; after release, ch0 wins first.
